// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the requester-side handshake and the data-memory pins of the
// dmem_arbiter into one interface.
//   slave  : the arbiter's view (requests and memory read data in,
//            grants/responses and memory strobes/address/data out).
//   master : the environment's view (requesters plus the data memory).
// Signals:
//   req[1:0], we[1:0]        per-port request and write select
//   addr0/1, wdata0/1        per-port byte address and write data
//   gnt, err, rvalid [1:0]   grant, range-error and read-response pulses
//   rdata                    shared read data
//   mem_readEn, mem_writeEn  memory strobes
//   mem_address, mem_dataIn  memory address and write data
//   mem_dataOut              combinational memory read data
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int WORD_LEN = 32
);
    logic [1:0]          req;
    logic [1:0]          we;
    logic [WORD_LEN-1:0] addr0;
    logic [WORD_LEN-1:0] addr1;
    logic [WORD_LEN-1:0] wdata0;
    logic [WORD_LEN-1:0] wdata1;
    logic [1:0]          gnt;
    logic [1:0]          err;
    logic [1:0]          rvalid;
    logic [WORD_LEN-1:0] rdata;
    logic                mem_readEn;
    logic                mem_writeEn;
    logic [WORD_LEN-1:0] mem_address;
    logic [WORD_LEN-1:0] mem_dataIn;
    logic [WORD_LEN-1:0] mem_dataOut;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_dataOut,
        output gnt, err, rvalid, rdata,
               mem_readEn, mem_writeEn, mem_address, mem_dataIn
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_dataOut,
        input  gnt, err, rvalid, rdata,
               mem_readEn, mem_writeEn, mem_address, mem_dataIn
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port round-robin arbiter/sequencer in front of the single-ported data
// memory. Port 0 is the CPU load/store port, port 1 an auxiliary master.
// An accepted request is registered in IDLE, driven onto the memory for one
// ACCESS cycle, range-checked, and answered with gnt (and err if out of range);
// reads return rvalid/rdata in the following cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : dmem_arbiter_if.slave (requester handshake + memory pins)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WORD_LEN  = 32,
    parameter int LOW_LIMIT = 1024,
    parameter int MEM_BYTES = 4096
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [WORD_LEN-1:0] ADDR_LO = WORD_LEN'(LOW_LIMIT);
    localparam logic [WORD_LEN-1:0] ADDR_HI = WORD_LEN'(MEM_BYTES - 4);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                id_q;
    logic                we_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic                oor_q;
    logic                last_q;

    logic [1:0]          rvalid_q;
    logic [WORD_LEN-1:0] rdata_q;

    logic                win;
    logic [WORD_LEN-1:0] sel_addr;
    logic [WORD_LEN-1:0] sel_aligned;
    logic                sel_oor;

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // On a tie the port that was not granted last wins; last_q resets to 1
    // so the first tie after reset goes to port 0.
    always_comb begin
        win = 1'b0;
        if (bus.req == 2'b10) begin
            win = 1'b1;
        end else if (bus.req == 2'b11) begin
            win = ~last_q;
        end
    end

    assign sel_addr    = win ? bus.addr1 : bus.addr0;
    assign sel_aligned = sel_addr & ~WORD_LEN'(3);
    assign sel_oor     = (sel_aligned < ADDR_LO) || (sel_aligned > ADDR_HI);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every access takes exactly one ACCESS cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture: the winner's request is frozen for the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (state_q == IDLE && |bus.req) begin
            id_q    <= win;
            we_q    <= bus.we[win];
            addr_q  <= sel_aligned;
            wdata_q <= win ? bus.wdata1 : bus.wdata0;
            oor_q   <= sel_oor;
            last_q  <= win;
        end
    end

    // Read response: suppressed (out-of-range) reads still respond, with 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 2'b00;
            if (state_q == ACCESS && !we_q) begin
                rvalid_q <= onehot(id_q);
                rdata_q  <= oor_q ? '0 : bus.mem_dataOut;
            end
        end
    end

    // Outputs: strobes only in an in-range ACCESS cycle.
    always_comb begin
        bus.gnt         = 2'b00;
        bus.err         = 2'b00;
        bus.mem_readEn  = 1'b0;
        bus.mem_writeEn = 1'b0;
        if (state_q == ACCESS) begin
            bus.gnt = onehot(id_q);
            if (oor_q) begin
                bus.err = onehot(id_q);
            end else begin
                bus.mem_writeEn = we_q;
                bus.mem_readEn  = ~we_q;
            end
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_dataIn  = wdata_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a word-addressed data memory model.
// Expected read responses are queued as requests are driven and compared when
// rvalid appears; grant, error and strobe behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [W-1:0] data;
    } resp_t;

    resp_t        sb[$];
    logic [W-1:0] mem    [0:1023];
    logic [W-1:0] shadow [0:1023];

    dmem_arbiter_if #(.WORD_LEN(W)) bus ();

    dmem_arbiter #(
        .WORD_LEN (W),
        .LOW_LIMIT(1024),
        .MEM_BYTES(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_dataOut = mem[bus.mem_address[11:2]];
    always @(posedge clk) begin
        if (bus.mem_writeEn) mem[bus.mem_address[11:2]] <= bus.mem_dataIn;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rvalid must match the oldest queued read.
    always @(negedge clk) begin
        if (bus.rvalid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, bus.rvalid}, 0);
            end else begin
                resp_t r;
                r = sb.pop_front();
                chk("rvalid_port", {30'd0, bus.rvalid}, (r.port == 1) ? 2 : 1);
                chk("rdata", bus.rdata, r.data);
            end
        end
    end

    function automatic bit is_oor(input logic [W-1:0] a);
        logic [W-1:0] al;
        al = a & ~32'd3;
        return (al < 32'd1024) || (al > 32'd4092);
    endfunction

    // One request on port p, held until its grant; returns the grant cycle.
    task automatic access(input int p, input bit w, input logic [W-1:0] a,
                          input logic [W-1:0] d, output int gcyc);
        bit           oor;
        logic [W-1:0] al;
        resp_t        r;
        oor = is_oor(a);
        al  = a & ~32'd3;
        bus.req      = (p == 1) ? 2'b10 : 2'b01;
        bus.we[p]    = w;
        if (p == 1) begin bus.addr1 = a; bus.wdata1 = d; end
        else        begin bus.addr0 = a; bus.wdata0 = d; end
        if (!w) begin
            r.port = p;
            r.data = oor ? 32'd0 : shadow[al[11:2]];
            sb.push_back(r);
        end else if (!oor) begin
            shadow[al[11:2]] = d;
        end
        tick();
        gcyc = cyc;
        chk("gnt", {30'd0, bus.gnt}, (p == 1) ? 2 : 1);
        chk("err", {30'd0, bus.err}, oor ? ((p == 1) ? 2 : 1) : 0);
        chk("mem_writeEn", {31'd0, bus.mem_writeEn}, {31'd0, w & ~oor});
        chk("mem_readEn", {31'd0, bus.mem_readEn}, {31'd0, ~w & ~oor});
        chk("mem_address", bus.mem_address, al);
        if (w) chk("mem_dataIn", bus.mem_dataIn, d);
        bus.req = 2'b00;
        tick();
        chk("gnt_idle", {30'd0, bus.gnt}, 0);
    endtask

    initial begin
        int g1, g2, gx;
        resp_t r;

        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
        end

        // Reset held two cycles with both ports requesting.
        bus.req = 2'b11; bus.we = 2'b00;
        bus.addr0 = 32'h400; bus.addr1 = 32'h404;
        bus.wdata0 = 0; bus.wdata1 = 0;
        tick();
        chk("rst_gnt", {30'd0, bus.gnt}, 0);
        chk("rst_err", {30'd0, bus.err}, 0);
        chk("rst_rvalid", {30'd0, bus.rvalid}, 0);
        chk("rst_strobes", {30'd0, bus.mem_readEn, bus.mem_writeEn}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_dataIn", bus.mem_dataIn, 0);
        tick();
        chk("rst_gnt2", {30'd0, bus.gnt}, 0);
        rst = 1'b0;

        // First tie after reset goes to port 0.
        r.port = 0; r.data = shadow[256];
        sb.push_back(r);
        tick();
        chk("tie_first_gnt", {30'd0, bus.gnt}, 1);
        chk("tie_first_readEn", {31'd0, bus.mem_readEn}, 1);
        bus.req = 2'b00;
        tick();

        // Write then read back-to-back on port 0, then a write that must not
        // disturb rdata.
        access(0, 1'b1, 32'h400, 32'hDEAD_BEEF, g1);
        access(0, 1'b0, 32'h402, 32'h0, g2);
        chk("b2b_gap", g2 - g1, 2);
        access(0, 1'b1, 32'h404, 32'h1234_5678, gx);
        chk("rdata_hold", bus.rdata, 32'hDEAD_BEEF);

        // Out of range: write at MEM_BYTES, read just below LOW_LIMIT.
        access(0, 1'b1, 32'd4096, 32'h5555_AAAA, gx);
        access(1, 1'b0, 32'h3FC, 32'h0, gx);
        chk("oor_rdata", bus.rdata, 0);

        // Contention: both ports stream reads, grants alternate from port 0.
        bus.we = 2'b00; bus.addr0 = 32'h404; bus.addr1 = 32'h408;
        for (int k = 0; k < 4; k++) begin
            r.port = k % 2;
            r.data = (k % 2) ? shadow[258] : shadow[257];
            sb.push_back(r);
        end
        bus.req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) chk("contend_gnt", {30'd0, bus.gnt}, ((k / 2) % 2) ? 2 : 1);
            else            chk("contend_gap", {30'd0, bus.gnt}, 0);
        end
        bus.req = 2'b00;
        tick();

        // Top of memory: unaligned write lands on MEM_BYTES-4, then read back.
        access(1, 1'b1, 32'hFFF, 32'hCAFE_F00D, gx);
        access(1, 1'b0, 32'hFFC, 32'h0, gx);
        access(0, 1'b1, 32'h500, 32'h0BAD_CAFE, gx);
        chk("top_rdata", bus.rdata, 32'hCAFE_F00D);

        // Reset during the ACCESS cycle of a read: dropped, pointer back to 1.
        bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h400;
        tick();
        chk("mid_gnt", {30'd0, bus.gnt}, 1);
        rst = 1'b1;
        bus.req = 2'b00;
        tick();
        chk("mid_rvalid", {30'd0, bus.rvalid}, 0);
        chk("mid_strobes", {30'd0, bus.mem_readEn, bus.mem_writeEn}, 0);
        chk("mid_gnt_after", {30'd0, bus.gnt}, 0);
        rst = 1'b0;
        tick();
        chk("mid_idle_gnt", {30'd0, bus.gnt}, 0);
        r.port = 0; r.data = shadow[256];
        sb.push_back(r);
        bus.req = 2'b11; bus.addr1 = 32'h408;
        tick();
        chk("mid_ptr_tie", {30'd0, bus.gnt}, 1);
        bus.req = 2'b00;
        tick();
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
